// File: rtl/ysyx_22050854_mul_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, operand-sign
// encodings, Booth digit decode and the per-mode iteration count.
package ysyx_22050854_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // mul_signed[1] = multiplicand signed, mul_signed[0] = multiplier signed
  typedef enum logic [1:0] {
    MS_UU = 2'b00,
    MS_US = 2'b01,
    MS_SU = 2'b10,
    MS_SS = 2'b11
  } mul_sgn_e;

  typedef enum logic [2:0] {
    DIG_ZERO,
    DIG_P1,
    DIG_P2,
    DIG_M1,
    DIG_M2
  } booth_dig_e;

  // Radix-4 Booth recoding of {y[i+1], y[i], y[i-1]}.
  function automatic booth_dig_e booth_decode(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return DIG_P1;
      3'b011:         return DIG_P2;
      3'b100:         return DIG_M2;
      3'b101, 3'b110: return DIG_M1;
      default:        return DIG_ZERO;
    endcase
  endfunction

  function automatic int iter_count(input int xlen, input logic mulw);
    return mulw ? (xlen / 4 + 1) : (xlen / 2 + 1);
  endfunction

endpackage

// File: rtl/ysyx_22050854_booth_r4_pp.sv
// Radix-4 Booth partial-product selector. Negative digits return the inverted
// magnitude; the +1 of the two's complement is handed back as o_neg.
module ysyx_22050854_booth_r4_pp
  import ysyx_22050854_mul_pkg::*;
#(
  parameter int W = 132
) (
  input  logic [2:0]   i_digit,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_pp,
  output logic         o_neg
);

  booth_dig_e w_dig;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_pp  = '0;
    o_neg = 1'b0;
    w_dig = booth_decode(i_digit);
    case (w_dig)
      DIG_P1: o_pp = i_x;
      DIG_P2: o_pp = i_x << 1;
      DIG_M1: begin
        o_pp  = ~i_x;
        o_neg = 1'b1;
      end
      DIG_M2: begin
        o_pp  = ~(i_x << 1);
        o_neg = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22050854_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier (full 2*XLEN product or signed W-mode).
// Optional feature: define MUL_EARLY_TERM_EN to stop once remaining digits are all zero.
module ysyx_22050854_booth_mul_seq
  import ysyx_22050854_mul_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo,
  output logic            busy
);

  localparam int AW = 2 * XLEN + 4;
  localparam int YW = XLEN + 3;
  localparam int HW = XLEN / 2;
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(iter_count(XLEN, 1'b0));
  localparam logic [CNT_W-1:0] N_HALF = CNT_W'(iter_count(XLEN, 1'b1));

  mul_state_e       r_state;
  logic [AW-1:0]    r_x;
  logic [AW-1:0]    r_acc;
  logic [YW-1:0]    r_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mulw;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;

  logic [XLEN-1:0]  w_x_src;
  logic [XLEN-1:0]  w_y_src;
  logic             w_x_sgn;
  logic             w_y_sgn;
  logic [AW-1:0]    w_pp;
  logic             w_neg;
  logic [CNT_W-1:0] w_n;
  logic             w_last;

  always_comb begin
    if (mulw) begin
      w_x_src = {{HW{multiplicand[HW-1]}}, multiplicand[HW-1:0]};
      w_y_src = {{HW{multiplier[HW-1]}}, multiplier[HW-1:0]};
      w_x_sgn = multiplicand[HW-1];
      w_y_sgn = multiplier[HW-1];
    end else begin
      w_x_src = multiplicand;
      w_y_src = multiplier;
      w_x_sgn = ((mul_signed == MS_SS) || (mul_signed == MS_SU)) && multiplicand[XLEN-1];
      w_y_sgn = ((mul_signed == MS_SS) || (mul_signed == MS_US)) && multiplier[XLEN-1];
    end
  end

  assign w_n = r_mulw ? N_HALF : N_FULL;

`ifdef MUL_EARLY_TERM_EN
  // Gated on r_cnt so at least one iteration runs (minimum latency of two edges).
  assign w_last = (r_cnt == w_n) || ((r_cnt != '0) && ((&r_y) || (~|r_y)));
`else
  assign w_last = (r_cnt == w_n);
`endif

  ysyx_22050854_booth_r4_pp #(
    .W(AW)
  ) u_pp (
    .i_digit(r_y[2:0]),
    .i_x    (r_x),
    .o_pp   (w_pp),
    .o_neg  (w_neg)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every
  // read in this block sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_mulw  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x     <= {{(AW - XLEN){w_x_sgn}}, w_x_src};
            r_y     <= {{2{w_y_sgn}}, w_y_src, 1'b0};
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mulw  <= mulw;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_last) begin
            if (r_mulw) begin
              r_hi <= {{HW{r_acc[XLEN-1]}}, r_acc[XLEN-1:HW]};
              r_lo <= {{HW{r_acc[HW-1]}}, r_acc[HW-1:0]};
            end else begin
              r_hi <= r_acc[2*XLEN-1:XLEN];
              r_lo <= r_acc[XLEN-1:0];
            end
            r_state <= ST_DONE;
          end else begin
            r_acc <= r_acc + w_pp + AW'(w_neg);
            r_x   <= r_x << 2;
            r_y   <= {{2{r_y[YW-1]}}, r_y[YW-1:2]};
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result_hi = r_hi;
  assign result_lo = r_lo;

endmodule

// File: tb/tb_ysyx_22050854_booth_mul_seq.sv
// Scoreboard bench for the Booth multiplier: directed vectors push expected
// products, a negedge monitor pops and compares on each result handshake.
`ifdef MUL_EARLY_TERM_EN
  `define TB_LAT(off, early) (early)
`else
  `define TB_LAT(off, early) (off)
`endif

module tb_ysyx_22050854_booth_mul_seq;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            mulw = 1'b0;
  logic [1:0]      mul_signed = 2'b00;
  logic [XLEN-1:0] multiplicand = '0;
  logic [XLEN-1:0] multiplier = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;
  logic            busy;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic [127:0] prod;
    string        name;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ysyx_22050854_booth_mul_seq #(
    .XLEN (XLEN),
    .CNT_W(7)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mulw        (mulw),
    .mul_signed  (mul_signed),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares on every result handshake seen at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 128'(sb_q.size()), 128'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, {result_hi, result_lo}, e.prod);
      end
    end
  end

  task automatic start_op(input logic w, input logic [1:0] sg, input logic [63:0] x, input logic [63:0] y);
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    mulw         = w;
    mul_signed   = sg;
    multiplicand = x;
    multiplier   = y;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input string name, input logic [63:0] hi, input logic [63:0] lo, input int lat);
    int n = 0;
    sb_q.push_back('{prod: {hi, lo}, name: name});
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
`ifdef MUL_EARLY_TERM_EN
    check({name, "_lat_range"}, 128'((n >= 2) && (n <= lat)), 128'd1);
`else
    check({name, "_latency"}, 128'(n), 128'(lat));
`endif
  endtask

  task automatic run_op(input string name, input logic w, input logic [1:0] sg, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] hi, input logic [63:0] lo, input int lat);
    start_op(w, sg, x, y);
    finish_op(name, hi, lo, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen;
    #3;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_result", {result_hi, result_lo}, 128'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_op("ss_m1_m1", 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h0, 64'h1, `TB_LAT(34, 34));
    run_op("uu_max_max", 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 64'h1, `TB_LAT(34, 34));
    run_op("su_m1_max", 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h1, `TB_LAT(34, 34));
    run_op("us_max_m1", 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h1, `TB_LAT(34, 34));
    run_op("w_7fff_x2", 1'b1, 2'b00, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002,
           64'h0, 64'hFFFF_FFFF_FFFF_FFFE, `TB_LAT(18, 18));
    run_op("w_min_m1", 1'b1, 2'b00, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'h0, 64'hFFFF_FFFF_8000_0000, `TB_LAT(18, 18));
    run_op("w_m3_x7", 1'b1, 2'b11, 64'h0000_0000_FFFF_FFFD, 64'h0000_0000_0000_0007,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, `TB_LAT(18, 18));
    run_op("ss_min_min", 1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 64'h0, `TB_LAT(34, 34));
    run_op("uu_2p32_sq", 1'b0, 2'b00, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
           64'h1, 64'h0, `TB_LAT(34, 34));
    run_op("su_min_max", 1'b0, 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, `TB_LAT(34, 34));
    run_op("us_2_m1", 1'b0, 2'b01, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, `TB_LAT(34, 34));

    // Flush at BUSY cycle 10: no result may ever appear for this op.
    start_op(1'b0, 2'b00, 64'd123, 64'h5555_5555_5555_5555);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 128'(busy), 128'd0);
    check("flush_in_ready", 128'(in_ready), 128'd1);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    check("flush_no_out_valid", 128'(seen), 128'd0);

    // Flush together with in_valid: the op must not be accepted.
    multiplicand = 64'd9;
    multiplier   = 64'd9;
    mul_signed   = 2'b11;
    mulw         = 1'b0;
    in_valid     = 1'b1;
    flush        = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_vs_accept_busy", 128'(busy), 128'd0);

    run_op("uu_3x5", 1'b0, 2'b00, 64'd3, 64'd5, 64'h0, 64'd15, `TB_LAT(34, 3));

    // Asynchronous reset mid-op clears everything without waiting for an edge.
    start_op(1'b0, 2'b11, 64'd7, 64'h5555_5555_5555_5555);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result", {result_hi, result_lo}, 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    step();
    rst_n = 1'b1;
    step();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    run_op("bp_m3_x7", 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, `TB_LAT(34, 34));
    multiplicand = 64'd2;
    multiplier   = 64'd2;
    in_valid     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold%0d_out_valid", i), 128'(out_valid), 128'd1);
      check($sformatf("hold%0d_in_ready", i), 128'(in_ready), 128'd0);
      check($sformatf("hold%0d_result", i), {result_hi, result_lo},
            {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    check("bp_release_busy", 128'(busy), 128'd0);

    repeat (3) step();
    check("sb_drain", 128'(sb_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`undef TB_LAT
